// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Tags identify which port a pending read response belongs to.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } port_tag_e;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 2;

endpackage

// File: rtl/arb_resp_pipe.sv
// MEM_LAT-deep tag shift register; the head tag tells which port owns the
// read data currently presented by the memory.
module arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  port_tag_e push_tag,
  output port_tag_e head_tag
);

  port_tag_e stage_q [MEM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_LAT; k++) stage_q[k] <= TAG_NONE;
    end else begin
      stage_q[0] <= push_tag;
      for (int k = 1; k < MEM_LAT; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign head_tag = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and
// data load/store, routing each read response back to its issuing port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  port_tag_e        push_tag;
  port_tag_e        head_tag;

  // Handshake: a requester holds req and payload stable until it sees gnt
  // high at a rising edge; req & gnt at that edge is the transfer. gnt is
  // combinational from req and starve_cnt only, and is forced low in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (d_req && !(i_req && starve_cnt == STARVE_LIM)) d_gnt = 1'b1;
      else if (i_req)                                    i_gnt = 1'b1;
    end
  end

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_wr    = d_gnt & d_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  always_comb begin
    push_tag = TAG_NONE;
    if (i_gnt)               push_tag = TAG_I;
    else if (d_gnt && !d_wr) push_tag = TAG_D;
  end

  arb_resp_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_resp_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_tag (push_tag),
    .head_tag (head_tag)
  );

  assign i_rvalid = (head_tag == TAG_I);
  assign d_rvalid = (head_tag == TAG_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
